// File: rtl/fp_mont_alu.sv
// fp_mont_alu - shared prime-field arithmetic unit for the CSIDH-512 datapath.
//
// It does one operation at a time. The operation is picked by op:
//   00 word-serial Montgomery multiply  A*B*2^-N mod p
//   01 A+B mod p
//   10 A-B mod p
//   11 pass A
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   A, B      operands, must be < p; latched when an operation starts
//   op        operation select, latched when an operation starts
//   rst_mul   client hold/clear, active high; when low in IDLE an operation starts
//   mul       registered result in [0,p)
//   done_mul  result valid; held until rst_mul is sampled high
//
// Latency from the start edge e0: multiply e0+2s+1, add/sub e0+2, pass e0+1.

package fp_mont_pkg;
    localparam logic [511:0] CSIDH_P =
        512'h65b48e8f740f89bffc8ab0d15e3e4c4ab42d083aedc88c425afbfcc69322c9cda7aac6c567f35507516730cc1f0b4f25c2721bf457aca8351b81b90533c6c87b;

    // (-m)^-1 mod 2^512 for odd m. Newton iteration doubles the number of
    // correct low bits each step. It starts from 3 bits (m*m == 1 mod 8),
    // and 10 steps are more than enough.
    function automatic logic [511:0] neg_inv512(input logic [511:0] m);
        logic [511:0] x;
        x = m;
        for (int k = 0; k < 10; k++) x = x * (512'd2 - m * x);
        return -x;
    endfunction

    localparam logic [511:0] CSIDH_PINV = neg_inv512(CSIDH_P);
endpackage

module fp_mont_alu #(
    parameter int           N         = 512,
    parameter int           word_size = 32,
    parameter logic [N-1:0] p         = fp_mont_pkg::CSIDH_P,
    parameter logic [N-1:0] p_inv     = fp_mont_pkg::CSIDH_PINV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   op,
    input  logic         rst_mul,
    output logic [N-1:0] mul,
    output logic         done_mul
);
    localparam int W  = word_size;
    localparam int S  = N / W;
    localparam int TW = N + W + 2;
    localparam int IW = (S > 1) ? $clog2(S) : 1;
    localparam logic [W-1:0] P_PRIME = p_inv[W-1:0];
    localparam logic [1:0] OP_MUL = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10;

    typedef enum logic [2:0] {
        IDLE, MUL_ACC, MUL_RED, FINAL, ADDSUB, ADDCORR, PASS, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d, mul_q, mul_d;
    logic [1:0]      op_q, op_d;
    logic [TW-1:0]   t_q, t_d;
    logic [W-1:0]    m_q, m_d;
    logic [IW-1:0]   i_q, i_d;
    logic            done_q, done_d;

    logic [W-1:0]    b_word, m_new;
    logic [N+W-1:0]  prod_ab, prod_mp;
    logic [TW-1:0]   t_acc, t_red;
    logic [N:0]      raw;

    always_comb begin
        b_word  = b_q[int'(i_q) * W +: W];
        prod_ab = {{W{1'b0}}, a_q} * {{N{1'b0}}, b_word};
        t_acc   = t_q + TW'(prod_ab);
        // m is taken from the freshly accumulated T, in the same cycle.
        m_new   = t_acc[W-1:0] * P_PRIME;
        prod_mp = {{W{1'b0}}, p} * {{N{1'b0}}, m_q};
        // The low W bits of T + m*p are zero, so the shift drops nothing.
        t_red   = (t_q + TW'(prod_mp)) >> W;
        // For subtraction, bit N is the sign of A-B.
        raw     = (op_q == OP_SUB) ? ({1'b0, a_q} - {1'b0, b_q})
                                   : ({1'b0, a_q} + {1'b0, b_q});
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        t_d     = t_q;
        m_d     = m_q;
        i_d     = i_q;
        mul_d   = mul_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (!rst_mul) begin
                    a_d  = A;
                    b_d  = B;
                    op_d = op;
                    t_d  = '0;
                    i_d  = '0;
                    case (op)
                        OP_MUL:         state_d = MUL_ACC;
                        OP_ADD, OP_SUB: state_d = ADDSUB;
                        default:        state_d = PASS;
                    endcase
                end
            end
            MUL_ACC: begin
                t_d     = t_acc;
                m_d     = m_new;
                state_d = MUL_RED;
            end
            MUL_RED: begin
                t_d     = t_red;
                i_d     = i_q + 1'b1;
                state_d = (i_q == IW'(S - 1)) ? FINAL : MUL_ACC;
            end
            FINAL: begin
                // T < 2p here, so one conditional subtraction is enough.
                // T-p < p, so the low N bits hold all of it.
                mul_d   = (t_q >= TW'(p)) ? (t_q[N-1:0] - p) : t_q[N-1:0];
                done_d  = 1'b1;
                state_d = DONE;
            end
            ADDSUB: begin
                t_d     = TW'(raw);
                state_d = ADDCORR;
            end
            ADDCORR: begin
                if (op_q == OP_SUB)
                    mul_d = t_q[N] ? (t_q[N-1:0] + p) : t_q[N-1:0];
                else
                    mul_d = (t_q[N:0] >= {1'b0, p}) ? (t_q[N-1:0] - p) : t_q[N-1:0];
                done_d  = 1'b1;
                state_d = DONE;
            end
            PASS: begin
                mul_d   = a_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (rst_mul) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort: if rst_mul is high while busy, return to IDLE and keep the
        // previous result.
        if (rst_mul && state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
            mul_d   = mul_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            t_q     <= '0;
            m_q     <= '0;
            i_q     <= '0;
            mul_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            t_q     <= t_d;
            m_q     <= m_d;
            i_q     <= i_d;
            mul_q   <= mul_d;
            done_q  <= done_d;
        end
    end

    assign mul      = mul_q;
    assign done_mul = done_q;

endmodule

// File: tb/tb_fp_mont_alu.sv
// Self-checking bench for fp_mont_alu.
// The reference model is plain modular arithmetic:
//   - multiply: A*B mod p, followed by N modular halvings
//   - add and subtract: direct modular formulas
// One compare process samples #1 after every rising edge. While an operation
// is active it checks exact latency, result and hold. The rest of the time it
// checks that done_mul is low.

module tb_fp_mont_alu;
    localparam int N = 512;
    localparam logic [N-1:0] P =
        512'h65b48e8f740f89bffc8ab0d15e3e4c4ab42d083aedc88c425afbfcc69322c9cda7aac6c567f35507516730cc1f0b4f25c2721bf457aca8351b81b90533c6c87b;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rst_mul = 1'b1;
    logic [N-1:0] A = '0, B = '0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] mul;
    logic         done_mul;

    always #5 clk = ~clk;

    fp_mont_alu dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .op(op),
        .rst_mul(rst_mul), .mul(mul), .done_mul(done_mul)
    );

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit           active = 1'b0;
    int           start_cyc = 0, exp_lat = 0;
    logic [N-1:0] exp_val = '0;
    logic [N-1:0] fp1, x, hold_mul;

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [N-1:0] mont_model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] prod;
        logic [N:0]     r;
        prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        prod = prod % {{N{1'b0}}, P};
        r = prod[N:0];
        // multiply by 2^-1 mod p, N times
        for (int k = 0; k < N; k++)
            r = r[0] ? ((r + {1'b0, P}) >> 1) : (r >> 1);
        return r[N-1:0];
    endfunction

    function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [1:0] o);
        logic [N:0] s;
        case (o)
            2'b00: return mont_model(a, b);
            2'b01: begin
                s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
                return s[N-1:0];
            end
            2'b10:   return (a >= b) ? (a - b) : (a + P - b);
            default: return a;
        endcase
    endfunction

    function automatic logic [N-1:0] rnd_fe();
        logic [N-1:0] v;
        for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
        return v % P;
    endfunction

    // compare process
    always begin
        @(posedge clk);
        #1;
        if (active) begin
            if (cyc - start_cyc < exp_lat) begin
                chk("done_early", {{(N-1){1'b0}}, done_mul}, '0);
            end else begin
                chk("done_held", {{(N-1){1'b0}}, done_mul}, {{(N-1){1'b0}}, 1'b1});
                chk("result", mul, exp_val);
            end
        end else begin
            chk("done_idle", {{(N-1){1'b0}}, done_mul}, '0);
        end
    end

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [1:0] o, input logic [N-1:0] e);
        @(negedge clk);
        A = a; B = b; op = o; rst_mul = 1'b0;
        exp_val   = e;
        exp_lat   = (o == 2'b00) ? 33 : (o == 2'b11) ? 1 : 2;
        start_cyc = cyc + 1;
        active    = 1'b1;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [1:0] o, input logic [N-1:0] e, input int hold);
        bit got;
        got = 1'b0;
        start_op(a, b, o, e);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (done_mul) begin
                got = 1'b1;
                break;
            end
            // operands must already be latched
            A = ~a; B = ~b; op = ~o;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: op %0d never completed", o);
        end else begin
            chk("capture", mul, e);
        end
        repeat (hold) @(negedge clk);
        rst_mul = 1'b1;
        active  = 1'b0;
    endtask

    initial begin
        logic [N-1:0] a, b, e;
        logic [1:0]   o;
        logic [N:0]   big;
        #1 rst = 1'b0;
        #2;
        chk("reset_mul", mul, '0);
        chk("reset_done", {{(N-1){1'b0}}, done_mul}, '0);

        big = {1'b1, {N{1'b0}}};
        big = big % {1'b0, P};
        fp1 = big[N-1:0];
        // 2 < 2^512/p < 3, so R mod p = 2^512 - 2p
        chk("model_fp1", fp1, '0 - (P << 1));
        chk("model_one", mont_model(fp1, fp1), fp1);
        chk("model_unit", mont_model(fp1, 512'd7), 512'd7);
        chk("model_sub", model(512'd0, 512'd1, 2'b10), P - 1);

        @(negedge clk);
        rst = 1'b1;

        x = rnd_fe();
        run_op(fp1, fp1, 2'b00, fp1, 0);
        run_op('0, x, 2'b00, '0, 0);
        run_op(fp1, 512'd1, 2'b00, 512'd1, 0);
        run_op(fp1, P - 1, 2'b00, P - 1, 0);
        run_op(fp1, x, 2'b00, x, 3);
        run_op(P - 1, 512'd1, 2'b01, '0, 0);
        run_op(512'd5, 512'd3, 2'b01, 512'd8, 0);
        run_op('0, 512'd1, 2'b10, P - 1, 0);
        run_op(512'd5, 512'd3, 2'b10, 512'd2, 0);
        run_op(x, '0, 2'b11, x, 2);

        // abort a multiply partway through
        start_op(x, fp1, 2'b00, x);
        repeat (10) @(negedge clk);
        rst_mul  = 1'b1;
        active   = 1'b0;
        hold_mul = mul;
        repeat (40) @(negedge clk);
        chk("abort_mul_kept", mul, hold_mul);
        run_op(fp1, x, 2'b00, x, 0);

        // random back-to-back regression, like a controller issuing requests
        repeat (150) begin
            a = rnd_fe();
            b = rnd_fe();
            o = 2'($urandom_range(0, 3));
            e = model(a, b, o);
            run_op(a, b, o, e, int'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a multiply
        run_op(fp1, x, 2'b00, x, 0);
        start_op(fp1, fp1, 2'b00, fp1);
        repeat (10) @(negedge clk);
        active  = 1'b0;
        rst_mul = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_mul", mul, '0);
        chk("async_rst_done", {{(N-1){1'b0}}, done_mul}, '0);
        @(negedge clk);
        rst = 1'b1;
        run_op(fp1, fp1, 2'b00, fp1, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
